// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings for the transmitter and its arbiter,
// plus default sizing parameters.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_BITS = 8;
  localparam int unsigned DEFAULT_N_TICK    = 16;
  localparam int unsigned DEFAULT_TIMEOUT   = 200000;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'b001,
    ARB_START = 3'b010,
    ARB_WAIT  = 3'b100
  } arb_state_e;

  typedef enum logic [3:0] {
    TX_IDLE  = 4'b0001,
    TX_START = 4'b0010,
    TX_DATA  = 4'b0100,
    TX_STOP  = 4'b1000
  } tx_state_e;

  // Watchdog counter width; a disabled watchdog still needs a 1-bit vector.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Bundle between the byte producers / UART transmitter and tx_arbiter.
interface tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
  parameter int unsigned LEN_ID    = $clog2(N_REQ)
);

  logic [N_REQ-1:0]           i_req;
  logic [N_REQ*DATA_BITS-1:0] i_data;
  logic [N_REQ-1:0]           o_ack;
  logic                       o_tx_start;
  logic [DATA_BITS-1:0]       o_tx_data;
  logic                       i_tx_done;
  logic                       o_busy;
  logic [LEN_ID-1:0]          o_grant_id;
  logic                       o_error;

  modport master (
    input  i_req, i_data, i_tx_done,
    output o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_error
  );

  modport slave (
    output i_req, i_data, i_tx_done,
    input  o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_error
  );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping
// around the request vector.
module rr_select #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned LEN_ID = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [LEN_ID-1:0] ptr,
  output logic              valid,
  output logic [LEN_ID-1:0] grant
);

  always_comb begin
    int unsigned idx;
    valid = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = LEN_ID'(idx);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers,
// with a watchdog on transmitter completion.
module tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int unsigned LEN_ID    = $clog2(N_REQ)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  tx_arbiter_if.master  bus
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CntMax = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_e           state_q, state_d;
  logic [LEN_ID-1:0]    ptr_q, ptr_d;
  logic [LEN_ID-1:0]    grant_q, grant_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 sel_valid;
  logic [LEN_ID-1:0]    sel_grant;
  logic [DATA_BITS-1:0] sel_data;

  rr_select #(
    .N_REQ  (N_REQ),
    .LEN_ID (LEN_ID)
  ) u_rr_select (
    .req   (bus.i_req),
    .ptr   (ptr_q),
    .valid (sel_valid),
    .grant (sel_grant)
  );

  assign sel_data = bus.i_data[sel_grant*DATA_BITS +: DATA_BITS];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    start_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (sel_valid) begin
          grant_d          = sel_grant;
          data_d           = sel_data;
          ptr_d            = (sel_grant == LEN_ID'(N_REQ - 1)) ? '0 : sel_grant + 1'b1;
          ack_d[sel_grant] = 1'b1;
          start_d          = 1'b1;
          state_d          = ARB_START;
        end
      end
      ARB_START: begin
        cnt_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        // Completion takes priority over a simultaneous watchdog expiry.
        if (bus.i_tx_done) begin
          state_d = ARB_IDLE;
        end else if (TIMEOUT != 0 && cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = ARB_IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
        grant_d = '0;
        data_d  = '0;
      end
    endcase

    busy_d = (state_d == ARB_START) || (state_d == ARB_WAIT);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_ack      = ack_q;
  assign bus.o_tx_start = start_q;
  assign bus.o_tx_data  = data_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_grant_id = grant_q;
  assign bus.o_error    = err_q;

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter that shares one UART transmitter among `N_REQ` byte producers, such as ALU result, status and echo paths. It latches one byte from the granted requester and pulses the transmitter's start input. It then holds the byte stable until the transmitter reports frame completion, and only then serves the next requester. A watchdog returns the arbiter to idle and flags an error if completion never arrives.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2).
- `DATA_BITS`, 8, byte width; must match the transmitter.
- `TIMEOUT`, 200000, clock cycles allowed in WAIT_DONE; 0 disables the watchdog.
- `LEN_ID`, `$clog2(N_REQ)`, grant index width.

Ports (one clock; reset is asynchronous and active-low):
- `i_clock`  in  1  system clock, rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  N_REQ  per-requester byte-pending request.
- `i_data`  in  N_REQ*DATA_BITS  requester k byte at bits [k*DATA_BITS +: DATA_BITS].
- `o_ack`  out  N_REQ  one-cycle pulse: requester k's byte accepted.
- `o_tx_start`  out  1  one-cycle start pulse to the transmitter.
- `o_tx_data`  out  DATA_BITS  byte to the transmitter; stable from start until done.
- `i_tx_done`  in  1  transmitter frame-complete pulse (one cycle, end of stop bit).
- `o_busy`  out  1  high in START and WAIT_DONE.
- `o_grant_id`  out  LEN_ID  index of the current/last granted requester.
- `o_error`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- One-hot FSM with states IDLE, START, WAIT_DONE.
- IDLE, any `i_req` high:
  - Pick the first requester at or after pointer `ptr`, cyclically.
  - Latch its byte into `o_tx_data` and its index into `o_grant_id`.
  - Set `ptr` to (grant+1) mod N_REQ.
  - Go to START.
- IDLE, no request: hold all registers.
- START:
  - `o_tx_start`=1 and `o_ack[grant]`=1 for exactly this cycle.
  - Clear the watchdog counter; go to WAIT_DONE.
- WAIT_DONE:
  - `i_tx_done`=1: go to IDLE.
  - Else, if TIMEOUT≠0 and counter==TIMEOUT-1: pulse `o_error`, go to IDLE.
  - Else: increment the counter.
  - `i_tx_done` and expiry in the same cycle: done wins, no error.
- `i_tx_done` in IDLE or START: ignored.
- Illegal state: go to IDLE; clear counter and outputs.
- Requester rule: hold `i_req` and `i_data` stable until `o_ack`, then deassert `i_req` in the following cycle or present the next byte.
- Watchdog counter width: `$clog2(TIMEOUT+1)`, unsigned, no wrap (reset on entering WAIT_DONE).

## Timing
- Reset values: state IDLE, `ptr`=0, `o_ack`=0, `o_tx_start`=0, `o_tx_data`=0, `o_busy`=0, `o_grant_id`=0, `o_error`=0, counter 0.
- All outputs registered.
- Request seen in IDLE at cycle t: `o_tx_start`/`o_ack` high at t+1, `o_busy` high from t+1.
- `i_tx_done` at cycle d: IDLE at d+1 (`o_busy`=0). A pending request is granted at d+1, with start at d+2, when the transmitter is already back in idle.
- Minimum spacing between start pulses: 3 cycles plus frame time.
- Reset asserted mid-frame: all outputs clear immediately. The arbiter does not resend the interrupted byte; the requester has already been acked.

## Structure
- Shared package `uart_pkg` holds:
  - one-hot state encodings for `tx_arbiter` (`ARB_IDLE`, `ARB_START`, `ARB_WAIT`), alongside the transmitter encodings;
  - default `DATA_BITS`, `N_TICK`, `TIMEOUT`.
- One combinational sub-module, `rr_select` (inputs: request vector, `ptr`; outputs: valid, grant index), carries the priority rotation.

## Test plan
- Single request: `i_req`=0001, byte 0xA5. Expect:
  - `o_tx_start` and `o_ack`=0001 one cycle later;
  - `o_tx_data`=0xA5 held until `i_tx_done`;
  - `o_busy` low the cycle after done.
- All four requesting (0x10..0x13), each dropping its request after ack. Expect grants in order 0,1,2,3 and bytes 0x10..0x13 in that order. After reset with only requesters 2 and 1 requesting, expect grant order 1 then 2.
- Fairness: requester 0 requests continuously and requester 3 requests once. Expect a grant to 3 no later than the second transmission.
- Watchdog: TIMEOUT=8, `i_tx_done` never asserted. Expect `o_error` pulse exactly 8 cycles after entering WAIT_DONE, then IDLE. `i_tx_done` and expiry in the same cycle: no error.
- Reset mid-WAIT_DONE: `i_reset` low for 1 cycle. Expect all outputs 0, `ptr`=0, and the next grant going to the lowest-index pending requester.
- Spurious `i_tx_done` in IDLE and in START: expect no state change and no extra start pulse.
